// File: rtl/byte_unstrip_pkg.sv
// Shared constants for the byte un-striper: default lane count and byte width.
// Carries no types of its own, only the defaults and a pointer-width helper.
package byte_unstrip_pkg;

    localparam int DEFAULT_LANES  = 4;
    localparam int DEFAULT_BYTE_W = 8;

    // A single-lane configuration still needs a 1-bit pointer to stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_unstrip_group_fifo.sv
// Two-entry group buffer with write/read pointers and an occupancy count.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module byte_unstrip_group_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Simultaneous push and pop leaves the count alone while both pointers move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/byte_unstrip.sv
// Serializes one parallel group of LANES bytes (each with a DK flag) back into
// a single byte stream in lane order, buffering up to two groups.
module byte_unstrip
    import byte_unstrip_pkg::*;
#(
    parameter int LANES  = DEFAULT_LANES,
    parameter int BYTE_W = DEFAULT_BYTE_W
) (
    input  logic                    CLK,
    input  logic                    RESET_L,
    input  logic [BYTE_W*LANES-1:0] LANE_D,
    input  logic [LANES-1:0]        LANE_DK,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [BYTE_W-1:0]       D,
    output logic                    DK,
    output logic                    O_VALID,
    input  logic                    O_READY
);

    localparam int              LP_W      = ptr_width(LANES);
    localparam int              ENTRY_W   = (BYTE_W + 1) * LANES;
    localparam logic [LP_W-1:0] LAST_LANE = LP_W'(LANES - 1);

    logic [ENTRY_W-1:0] head;
    logic [BYTE_W-1:0]  head_bytes [LANES];
    logic [LANES-1:0]   head_dk;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               xfer;
    logic [LP_W-1:0]    lp;

    // IN_READY comes straight from registered occupancy, never from O_READY.
    assign IN_READY = !full;
    assign push     = IN_VALID && !full;
    assign O_VALID  = !empty;
    assign xfer     = O_VALID && O_READY;
    assign pop      = xfer && (lp == LAST_LANE);

    byte_unstrip_group_fifo #(
        .WIDTH (ENTRY_W)
    ) u_group_fifo (
        .clk   (CLK),
        .rst_n (RESET_L),
        .push  (push),
        .pop   (pop),
        .wdata ({LANE_DK, LANE_D}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_dk = head[ENTRY_W-1 -: LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_unpack
        assign head_bytes[i] = head[i*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            lp <= '0;
        end else if (xfer) begin
            lp <= (lp == LAST_LANE) ? '0 : lp + 1'b1;
        end
    end

    // Idle output is forced to zero so stale buffer contents never leak out.
    always_comb begin
        D  = '0;
        DK = 1'b0;
        if (O_VALID) begin
            D  = head_bytes[lp];
            DK = head_dk[lp];
        end
    end

endmodule

// File: tb/tb_byte_unstrip.sv
// Directed bench for byte_unstrip with a byte scoreboard fed at group acceptance
// and drained at every output transfer.
module tb_byte_unstrip;

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic [31:0] LANE_D;
    logic [3:0]  LANE_DK;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  D;
    logic        DK;
    logic        O_VALID;
    logic        O_READY;

    logic [8:0]  exp_q [$];
    int          assert_cnt = 0;
    int          fail_cnt   = 0;

    byte_unstrip #(
        .LANES  (4),
        .BYTE_W (8)
    ) dut (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .LANE_D   (LANE_D),
        .LANE_DK  (LANE_DK),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .D        (D),
        .DK       (DK),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: compare departing bytes first, then record an accepted group.
    always @(negedge CLK) begin
        if (RESET_L === 1'b1) begin
            if (O_VALID && O_READY) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_unexpected", 32'(O_VALID), 32'd0);
                end else begin
                    check_output("sb_byte", 32'({DK, D}), 32'(exp_q.pop_front()));
                end
            end
            if (IN_VALID && IN_READY) begin
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back({LANE_DK[i], LANE_D[8*i +: 8]});
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] dk,
                                  input bit keep_valid);
        bit taken = 1'b0;
        LANE_D   = d;
        LANE_DK  = dk;
        IN_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (IN_READY) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            check_output("accept_timeout", 32'(IN_READY), 32'd1);
        end
        @(posedge CLK);
        #1;
        if (!keep_valid) begin
            IN_VALID = 1'b0;
        end
    endtask

    task automatic check_group_out(input logic [31:0] d, input logic [3:0] dk);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check_output("lane_valid", 32'(O_VALID), 32'd1);
            check_output("lane_d", 32'(D), 32'(d[8*k +: 8]));
            check_output("lane_dk", 32'(DK), 32'(dk[k]));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0 && !O_VALID) begin
                return;
            end
        end
        check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        RESET_L  = 1'b0;
        LANE_D   = '0;
        LANE_DK  = '0;
        IN_VALID = 1'b0;
        O_READY  = 1'b1;

        repeat (3) @(negedge CLK);
        check_output("rst_d", 32'(D), 32'h00);
        check_output("rst_dk", 32'(DK), 32'd0);
        check_output("rst_ovalid", 32'(O_VALID), 32'd0);
        check_output("rst_inready", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] single group latency and order");
        apply_stimulus(32'h44332211, 4'b0000, 1'b0);
        check_group_out(32'h44332211, 4'b0000);
        @(negedge CLK);
        check_output("idle_ovalid", 32'(O_VALID), 32'd0);
        check_output("idle_d", 32'(D), 32'h00);
        wait_drain();

        $display("[TB] back-to-back groups");
        apply_stimulus(32'h13121110, 4'b0000, 1'b1);
        fork
            begin
                apply_stimulus(32'h23222120, 4'b1000, 1'b1);
                apply_stimulus(32'h33323130, 4'b0001, 1'b0);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge CLK);
                    check_output("b2b_no_gap", 32'(O_VALID), 32'd1);
                end
            end
        join
        wait_drain();

        $display("[TB] control flags");
        apply_stimulus(32'h227C11BC, 4'b0101, 1'b0);
        check_group_out(32'h227C11BC, 4'b0101);
        wait_drain();

        $display("[TB] backpressure");
        O_READY = 1'b0;
        apply_stimulus(32'h0D0C0B0A, 4'b0010, 1'b0);
        apply_stimulus(32'h1D1C1B1A, 4'b0100, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check_output("bp_inready", 32'(IN_READY), 32'd0);
            check_output("bp_ovalid", 32'(O_VALID), 32'd1);
            check_output("bp_d_frozen", 32'(D), 32'h0A);
        end
        @(posedge CLK);
        #1;
        O_READY = 1'b1;
        wait_drain();

        $display("[TB] push and pop at full boundary");
        O_READY = 1'b0;
        apply_stimulus(32'h43424140, 4'b0000, 1'b0);
        apply_stimulus(32'h53525150, 4'b0000, 1'b0);
        LANE_D   = 32'h63626160;
        LANE_DK  = 4'b1001;
        IN_VALID = 1'b1;
        O_READY  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check_output("full_inready_low", 32'(IN_READY), 32'd0);
        end
        @(negedge CLK);
        check_output("full_inready_reopen", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check_output("full_refilled", 32'(IN_READY), 32'd0);
        wait_drain();

        $display("[TB] reset mid-group");
        apply_stimulus(32'h74737271, 4'b0000, 1'b0);
        apply_stimulus(32'h84838281, 4'b0000, 1'b0);
        @(posedge CLK);
        #1;
        RESET_L = 1'b0;
        #1;
        exp_q.delete();
        check_output("midrst_ovalid", 32'(O_VALID), 32'd0);
        check_output("midrst_d", 32'(D), 32'h00);
        check_output("midrst_dk", 32'(DK), 32'd0);
        check_output("midrst_inready", 32'(IN_READY), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        apply_stimulus(32'hDDCCBBAA, 4'b0000, 1'b0);
        @(negedge CLK);
        check_output("post_rst_first", 32'(D), 32'hAA);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
